// File: rtl/tb_cmd_pkg.sv
// Shared opcode/state types and the saturating error-count helper for the command sequencer.
package tb_cmd_pkg;

    typedef enum logic [1:0] {
        OP_SET = 2'd0,
        OP_WTR = 2'd1,
        OP_WTF = 2'd2,
        OP_CHK = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RETIRE = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tb_cmd_if.sv
// Command push port plus unit select/done bus between the sequencer (slave) and its environment (master).
interface tb_cmd_if #(
    parameter int ARG_W = 32,
    parameter int TMO_W = 16
);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [1:0]       i_cmd_op;
    logic [ARG_W-1:0] i_cmd_arg;
    logic [TMO_W-1:0] i_cmd_tmo;
    logic             o_sel_set;
    logic             o_sel_wait;
    logic             o_sel_check;
    logic [ARG_W-1:0] o_arg;
    logic             o_wait_rise;
    logic             i_set_done;
    logic             i_wait_done;
    logic             i_check_done;
    logic             i_check_ok;
    logic             o_cmd_done;
    logic             o_tmo_err;
    logic             o_chk_err;
    logic [7:0]       o_err_cnt;
    logic             o_busy;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_arg, i_cmd_tmo,
               i_set_done, i_wait_done, i_check_done, i_check_ok,
        input  o_cmd_ready, o_sel_set, o_sel_wait, o_sel_check, o_arg, o_wait_rise,
               o_cmd_done, o_tmo_err, o_chk_err, o_err_cnt, o_busy
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_arg, i_cmd_tmo,
               i_set_done, i_wait_done, i_check_done, i_check_ok,
        output o_cmd_ready, o_sel_set, o_sel_wait, o_sel_check, o_arg, o_wait_rise,
               o_cmd_done, o_tmo_err, o_chk_err, o_err_cnt, o_busy
    );

endinterface

// File: rtl/tb_cmd_fifo.sv
// Generic show-ahead FIFO: push visible at the head one cycle later; pop and push may share a cycle.
// Backpressure: full_o blocks pushes, pops on empty are ignored.
module tb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tb_cmd_sequencer.sv
// Queued command sequencer: push to unit select in 2 cycles, retire one cycle after done/timeout.
// Backpressure: o_cmd_ready drops while the command queue is full.
module tb_cmd_sequencer
    import tb_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ARG_W      = 32,
    parameter int TMO_W      = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    tb_cmd_if.slave bus
);
    localparam int ENT_W = 2 + ARG_W + TMO_W;

    logic [ENT_W-1:0]     head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 sel_any;
    logic                 unit_done;

    state_e               state_q;
    op_e                  op_q;
    logic [ARG_W-1:0]     arg_q;
    logic [TMO_W-1:0]     timer_q;
    logic                 sel_set_q;
    logic                 sel_wait_q;
    logic                 sel_check_q;
    logic                 wait_rise_q;
    logic                 cmd_done_q;
    logic                 tmo_err_q;
    logic                 chk_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign push = bus.i_cmd_valid && !fifo_full;
    assign pop  = (state_q == ST_RETIRE);

    tb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({bus.i_cmd_op, bus.i_cmd_arg, bus.i_cmd_tmo}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Only the strobe of the currently selected unit can complete a command.
    assign sel_any   = sel_set_q || sel_wait_q || sel_check_q;
    assign unit_done = (sel_set_q   && bus.i_set_done)  ||
                       (sel_wait_q  && bus.i_wait_done) ||
                       (sel_check_q && bus.i_check_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SET;
            arg_q       <= '0;
            timer_q     <= '0;
            sel_set_q   <= 1'b0;
            sel_wait_q  <= 1'b0;
            sel_check_q <= 1'b0;
            wait_rise_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            chk_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            cmd_done_q <= 1'b0;
            tmo_err_q  <= 1'b0;
            chk_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_EXEC;
                        op_q    <= op_e'(head[ENT_W-1 -: 2]);
                        arg_q   <= head[TMO_W +: ARG_W];
                        timer_q <= head[TMO_W-1:0];
                    end
                end
                ST_EXEC: begin
                    if (!sel_any) begin
                        // First EXEC cycle decodes the latched opcode into the select outputs.
                        sel_set_q   <= (op_q == OP_SET);
                        sel_wait_q  <= (op_q == OP_WTR) || (op_q == OP_WTF);
                        sel_check_q <= (op_q == OP_CHK);
                        wait_rise_q <= (op_q == OP_WTR);
                    end else if (unit_done || timer_q == TMO_W'(1)) begin
                        state_q     <= ST_RETIRE;
                        sel_set_q   <= 1'b0;
                        sel_wait_q  <= 1'b0;
                        sel_check_q <= 1'b0;
                        wait_rise_q <= 1'b0;
                        cmd_done_q  <= 1'b1;
                        if (!unit_done) begin
                            tmo_err_q <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end else if (sel_check_q && !bus.i_check_ok) begin
                            chk_err_q <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                    end else if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_RETIRE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_cmd_ready = !fifo_full;
    assign bus.o_sel_set   = sel_set_q;
    assign bus.o_sel_wait  = sel_wait_q;
    assign bus.o_sel_check = sel_check_q;
    assign bus.o_arg       = arg_q;
    assign bus.o_wait_rise = wait_rise_q;
    assign bus.o_cmd_done  = cmd_done_q;
    assign bus.o_tmo_err   = tmo_err_q;
    assign bus.o_chk_err   = chk_err_q;
    assign bus.o_err_cnt   = err_cnt_q;
    assign bus.o_busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tb_cmd_sequencer.sv
// Directed bench for tb_cmd_sequencer: stimulus pushes expected retirements, a monitor checks each o_cmd_done.
module tb_tb_cmd_sequencer;
    import tb_cmd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tb_cmd_if #(.ARG_W(32), .TMO_W(16)) bus ();

    tb_cmd_sequencer #(
        .FIFO_DEPTH (4),
        .ARG_W      (32),
        .TMO_W      (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] arg;
        bit          tmo;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_cnt   = 0;
    int   resp_delay = -1;
    bit   noise      = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] arg, input logic [15:0] tmo,
                        input bit etmo, input bit echk, input int ecyc);
        int   n;
        exp_t e;
        n = 0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_op    = op;
        bus.i_cmd_arg   = arg;
        bus.i_cmd_tmo   = tmo;
        while (!bus.o_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_wait: ready stayed low for %0d cycles, required within 200", n);
            bus.i_cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.op = op; e.arg = arg; e.tmo = etmo; e.chk = echk; e.cyc = ecyc;
            exp_q.push_back(e);
            @(negedge clk);
            bus.i_cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((bus.o_busy || exp_q.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL idle_wait: busy=%0b pending=%0d after %0d cycles, required idle", bus.o_busy, exp_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", bus.o_cmd_ready, 1);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_err_cnt", bus.o_err_cnt, 0);
        chk("rst_sels", {bus.o_sel_set, bus.o_sel_wait, bus.o_sel_check}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Unit responder: selected unit strobes done after resp_delay select cycles; others strobe as noise.
    initial begin
        int  rcnt;
        bit  hit;
        rcnt = 0;
        bus.i_set_done   = 1'b0;
        bus.i_wait_done  = 1'b0;
        bus.i_check_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.o_sel_set || bus.o_sel_wait || bus.o_sel_check)) rcnt++;
            else rcnt = 0;
            hit = (resp_delay >= 0) && (rcnt == resp_delay + 1);
            bus.i_set_done   = bus.o_sel_set   ? hit : noise;
            bus.i_wait_done  = bus.o_sel_wait  ? hit : noise;
            bus.i_check_done = bus.o_sel_check ? hit : noise;
        end
    end

    // Monitor: pops one expectation per retirement and compares what the DUT showed while executing.
    initial begin
        int          sel_cyc;
        logic [31:0] first_arg;
        logic [31:0] last_arg;
        logic [1:0]  cur_op;
        exp_t        e;
        sel_cyc = 0; first_arg = '0; last_arg = '0; cur_op = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sel_cyc = 0;
            end else begin
                if (bus.o_sel_set || bus.o_sel_wait || bus.o_sel_check) begin
                    chk("onehot", $countones({bus.o_sel_set, bus.o_sel_wait, bus.o_sel_check}), 1);
                    cur_op = bus.o_sel_set ? 2'd0 : bus.o_sel_wait ? (bus.o_wait_rise ? 2'd1 : 2'd2) : 2'd3;
                    if (sel_cyc == 0) first_arg = bus.o_arg;
                    last_arg = bus.o_arg;
                    sel_cyc++;
                end
                if (bus.o_cmd_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got a retirement, required none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("ret_op", cur_op, e.op);
                        chk("ret_arg_first", first_arg, e.arg);
                        chk("ret_arg_last", last_arg, e.arg);
                        chk("ret_tmo_err", bus.o_tmo_err, e.tmo);
                        chk("ret_chk_err", bus.o_chk_err, e.chk);
                        chk("ret_sel_cycles", sel_cyc, e.cyc);
                    end
                    sel_cyc = 0;
                end else if (bus.o_tmo_err || bus.o_chk_err) begin
                    checks++;
                    errors++;
                    $display("FAIL err_pulse: tmo=%0b chk=%0b without done, required none", bus.o_tmo_err, bus.o_chk_err);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = '0;
        bus.i_cmd_arg   = '0;
        bus.i_cmd_tmo   = '0;
        bus.i_check_ok  = 1'b1;
        #1;
        chk("init_ready", bus.o_cmd_ready, 1);
        chk("init_busy", bus.o_busy, 0);
        chk("init_done", bus.o_cmd_done, 0);
        chk("init_err_cnt", bus.o_err_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // SET with done three cycles into the select; select appears two edges after the push.
        resp_delay = 3;
        d0 = done_cnt;
        send(OP_SET, 32'h12, 16'd0, 1'b0, 1'b0, 4);
        @(negedge clk);
        chk("s1_sel_edge1", bus.o_sel_set, 0);
        @(negedge clk);
        chk("s1_sel_edge2", bus.o_sel_set, 1);
        chk("s1_arg", bus.o_arg, 32'h12);
        wait_idle(100);
        chk("s1_done_cnt", done_cnt, d0 + 1);
        chk("s1_err_cnt", bus.o_err_cnt, 0);

        // WTF times out after five select cycles.
        do_reset();
        resp_delay = -1;
        send(OP_WTF, 32'hBEEF, 16'd5, 1'b1, 1'b0, 5);
        wait_idle(100);
        chk("s2_err_cnt", bus.o_err_cnt, 1);

        // Failing then passing CHK.
        do_reset();
        resp_delay = 1;
        bus.i_check_ok = 1'b0;
        send(OP_CHK, 32'hA5, 16'd0, 1'b0, 1'b1, 2);
        wait_idle(100);
        bus.i_check_ok = 1'b1;
        send(OP_CHK, 32'h5A, 16'd0, 1'b0, 1'b0, 2);
        wait_idle(100);
        chk("s3_err_cnt", bus.o_err_cnt, 1);

        // Five back-to-back pushes into a depth-4 queue behind a slow unit.
        do_reset();
        resp_delay = 6;
        send(OP_SET, 32'h100, 16'd0, 1'b0, 1'b0, 7);
        send(OP_WTR, 32'h101, 16'd0, 1'b0, 1'b0, 7);
        send(OP_WTF, 32'h102, 16'd0, 1'b0, 1'b0, 7);
        send(OP_CHK, 32'h103, 16'd0, 1'b0, 1'b0, 7);
        chk("s4_ready_full", bus.o_cmd_ready, 0);
        chk("s4_busy", bus.o_busy, 1);
        send(OP_SET, 32'h104, 16'd0, 1'b0, 1'b0, 7);
        wait_idle(400);
        chk("s4_err_cnt", bus.o_err_cnt, 0);

        // Done on the expiry cycle wins; one cycle later is a timeout; then saturate the counter.
        do_reset();
        resp_delay = 3;
        send(OP_WTR, 32'h77, 16'd4, 1'b0, 1'b0, 4);
        wait_idle(100);
        chk("s5_done_wins_err_cnt", bus.o_err_cnt, 0);
        resp_delay = 4;
        send(OP_WTR, 32'h78, 16'd4, 1'b1, 1'b0, 4);
        wait_idle(100);
        chk("s5_late_done_err_cnt", bus.o_err_cnt, 1);
        resp_delay = -1;
        for (int i = 0; i < 300; i++) send(OP_WTF, 32'(i), 16'd1, 1'b1, 1'b0, 1);
        wait_idle(3000);
        chk("s5_err_cnt_sat", bus.o_err_cnt, 255);

        // Asynchronous reset while a command is executing.
        do_reset();
        resp_delay = -1;
        send(OP_SET, 32'h33, 16'd0, 1'b0, 1'b0, 0);
        n = 0;
        while (!bus.o_sel_set && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s6_sel_before_rst", bus.o_sel_set, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("s6_sels_async", {bus.o_sel_set, bus.o_sel_wait, bus.o_sel_check}, 0);
        chk("s6_busy", bus.o_busy, 0);
        chk("s6_ready", bus.o_cmd_ready, 1);
        chk("s6_arg", bus.o_arg, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("s6_no_done", done_cnt, d0);
        chk("s6_busy_after", bus.o_busy, 0);

        chk("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
